uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with 16x oversampling, majority-vote bit sampling, optional parity, per-character error flags and an output FIFO with a valid/ready handshake. It is the serial-input front end of the pipeline CPU's peripheral bus: the `rxd` pin enters here and the CPU drains characters at its own pace. The default configuration is 50 MHz / 9600 baud 8N1, the board's standard link. Width, parity mode, baud rate and buffer depth are configurable.

## Interface
- `CLK_HZ`, 50000000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `DATA_BITS`, 8: data bits per frame. Legal values are 5 to 8.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `FIFO_DEPTH`, 16: number of FIFO entries. Must be a power of two and at least 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  serial input. Asynchronous to `clk`; idles high.
- `rx_data`  out  DATA_BITS  FIFO head character.
- `rx_perr`  out  1  parity error flag of the head character. 0 when `PARITY`=0.
- `rx_ferr`  out  1  framing error flag of the head character (stop bit sampled 0).
- `rx_valid`  out  1  FIFO is non-empty; head outputs are valid.
- `rx_ready`  in  1  consumer accepts the head entry.
- `overflow`  out  1  sticky flag: a character was dropped because the FIFO was full.
- `clr_ovf`  in  1  single-cycle pulse that clears `overflow`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.

## Operation
- **Synchroniser:** `rxd` passes through 2 flops, both reset to 1. All decisions use the synchronised value `rxs`.
- **Oversample tick:** DIV = (CLK_HZ + 8·BAUD) / (16·BAUD), integer division. This gives 326 at the defaults.
  - The tick counter free-runs from 0 to DIV-1 and produces a 1-cycle `tick` when it wraps.
  - A 4-bit sample counter `sc` advances on `tick` inside a frame.
- **Bit value:** majority of `rxs` at sc = 7, 8 and 9. It is evaluated at sc = 9.
- **IDLE:** on a `tick` with `rxs`=0, clear `sc` and go to START.
- **START:** at sc=9, if the majority is 1 this is a false start: return to IDLE and push nothing. At sc=15, go to DATA.
- **DATA:** shift each majority value in LSB first. After bit DATA_BITS-1 reaches sc=15, go to PARITY if PARITY≠0, else STOP.
- **PARITY:** compute `perr` at sc=9.
  - Odd mode: `perr` = 1 unless data XOR parity bit = 1.
  - Even mode: `perr` = 1 unless data XOR parity bit = 0.
  - At sc=15, go to STOP.
- **STOP:** at sc=9, `ferr` = ~majority. Push {data, perr, ferr} and return to IDLE.
  - Returning at sc=9 rather than the bit end allows back-to-back frames at +3% baud error.
  - A break (all zeros, `ferr`=1) is pushed like any other character.
- **FIFO:** circular buffer with read/write pointers one bit wider than the address; full is when the MSBs differ and the rest are equal.
  - Pop when `rx_valid && rx_ready`. Push when a STOP evaluation completes.
  - Push while full and no pop: the character is discarded and `overflow` sets.
  - Push while full with a simultaneous pop: both happen and `fifo_count` stays at FIFO_DEPTH.
  - Push and pop in the same cycle otherwise: both happen and the count is unchanged.
  - Pop while empty is ignored.
- **Overflow flag:** `clr_ovf` clears `overflow`. If `clr_ovf` and a new overflow occur in the same cycle, set wins.

## Timing
- **Reset values:** `rx_data`=0, `rx_perr`=0, `rx_ferr`=0, `rx_valid`=0, `overflow`=0, `fifo_count`=0. The FSM is in IDLE and both counters are at 0.
- **Reset mid-frame:** the partial character is lost and the FIFO is emptied.
- **Head outputs:** registered. They are updated the cycle after a push into an empty FIFO or after a pop.
  - `rx_valid` rises 1 clk after the push cycle.
  - The next entry is presented 1 clk after a pop. `rx_valid` stays high while entries remain.
- **Frame latency:** the push happens (1 + DATA_BITS + (PARITY≠0))·16 + 9 ticks after the start-detect tick.
  - Start-detect itself lags the falling edge by 2 clk of synchroniser plus up to 1 tick of quantisation.
- **Throughput:** 1 pop per clk.
- **Counter update:** `fifo_count` is registered and changes in the same edge as the pointer update.

## Test plan
- **Default 8N1 receive:** 9600 baud, send 0x01 with 104166.667 ns bits. Expect `rx_data`=0x01, `rx_valid`=1, `rx_perr`=0, `rx_ferr`=0. Raising `rx_ready` for 1 clk returns `rx_valid` to 0 and `fifo_count` to 0.
- **Even parity:** PARITY=2.
  - Send 0xA5 with parity bit 0: expect `rx_perr`=0.
  - Send 0xA5 with parity bit 1: expect `rx_perr`=1 and `rx_data`=0xA5.
- **Framing error and false start:**
  - Send 0x3C with the stop bit held low: expect `rx_ferr`=1.
  - Drive a 3 µs low glitch on an idle line: expect no push and `fifo_count` to stay 0.
- **Overflow:** FIFO_DEPTH=4, `rx_ready`=0, send 0x11, 0x22, 0x33, 0x44, 0x55.
  - Expect `fifo_count`=4 and `overflow`=1.
  - Popping then yields 0x11, 0x22, 0x33, 0x44, in that order.
  - `clr_ovf` clears `overflow`.
- **Full with simultaneous pop:** with the FIFO full, hold `rx_ready`=1 in the push cycle. Expect the character to be accepted, `fifo_count` to stay at 4, and `overflow` to stay 0.
- **Reset mid-frame and back-to-back:**
  - Assert `reset` low during data bit 4, then release and send 0x5A. Expect exactly one entry, 0x5A.
  - Send 0x00, 0xFF back-to-back at +3% baud. Expect both characters received with no errors.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversample, 2-of-3 vote, optional parity) feeding a valid/ready FIFO; push lands mid stop bit.
// Head is registered (valid 1 clk after push into empty); full FIFO drops new characters unless popped that cycle.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rxd,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          overflow,
    input  logic                          clr_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int EW  = DATA_BITS + 2;
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    logic [1:0]           sync_q;
    logic                 rxs;
    logic [CW-1:0]        cnt_q;
    logic                 tick;

    state_t               state_q, state_d;
    logic [3:0]           sc_q, sc_d, sc_inc;
    logic [2:0]           bit_q, bit_d;
    logic                 s7_q, s7_d, s8_q, s8_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 maj;
    logic                 push, push_ferr;
    logic [EW-1:0]        wdat;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW:0]          wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic [EW-1:0]        head_q, head_d;
    logic                 valid_q, ovf_q, ovf_d;
    logic                 full, pop, wr, head_en;

    assign rxs  = sync_q[1];
    assign tick = (cnt_q == DIV_LAST);
    assign maj  = (s7_q & s8_q) | (s7_q & rxs) | (s8_q & rxs);
    assign wdat = {shift_q, perr_q, push_ferr};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], rxd};
            cnt_q  <= tick ? '0 : cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sc_q    <= '0;
            bit_q   <= '0;
            s7_q    <= 1'b1;
            s8_q    <= 1'b1;
            shift_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            bit_q   <= bit_d;
            s7_q    <= s7_d;
            s8_q    <= s8_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
        end
    end

    // Actions key on the post-increment sample index so the start-detect tick counts as sc=0.
    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        bit_d     = bit_q;
        s7_d      = s7_q;
        s8_d      = s8_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        push      = 1'b0;
        push_ferr = 1'b0;
        sc_inc    = sc_q + 4'd1;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        sc_d    = '0;
                        bit_d   = '0;
                        perr_d  = 1'b0;
                        state_d = S_START;
                    end
                end
                default: begin
                    sc_d = sc_inc;
                    if (sc_inc == 4'd7) s7_d = rxs;
                    if (sc_inc == 4'd8) s8_d = rxs;
                    case (state_q)
                        S_START: begin
                            if (sc_inc == 4'd9 && maj) state_d = S_IDLE;
                            else if (sc_inc == 4'd15)  state_d = S_DATA;
                        end
                        S_DATA: begin
                            if (sc_inc == 4'd9) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                            if (sc_inc == 4'd15) begin
                                if (bit_q == BIT_LAST) state_d = (PARITY != 0) ? S_PAR : S_STOP;
                                else                   bit_d   = bit_q + 3'd1;
                            end
                        end
                        S_PAR: begin
                            if (sc_inc == 4'd9)
                                perr_d = (PARITY == 1) ? ~(^shift_q ^ maj) : (^shift_q ^ maj);
                            if (sc_inc == 4'd15) state_d = S_STOP;
                        end
                        S_STOP: begin
                            if (sc_inc == 4'd9) begin
                                push      = 1'b1;
                                push_ferr = ~maj;
                                state_d   = S_IDLE;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            endcase
        end
    end

    assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop  = valid_q && rx_ready;
    assign wr   = push && (!full || pop);

    always_comb begin
        rptr_d  = pop ? rptr_q + PTR_ONE : rptr_q;
        wptr_d  = wr  ? wptr_q + PTR_ONE : wptr_q;
        count_d = count_q;
        if (wr && !pop)      count_d = count_q + PTR_ONE;
        else if (!wr && pop) count_d = count_q - PTR_ONE;
        // Freshly pushed word bypasses the array when it becomes the head in the same edge.
        head_d  = (wr && (wptr_q == rptr_d)) ? wdat : mem[rptr_d[AW-1:0]];
        head_en = pop ? ((count_q != PTR_ONE) || wr) : (wr && (count_q == '0));
        ovf_d   = ovf_q;
        if (push && full && !pop) ovf_d = 1'b1;
        else if (clr_ovf)         ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr_q[AW-1:0]] <= wdat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
            ovf_q   <= ovf_d;
            if (head_en) head_q <= head_d;
        end
    end

    assign rx_data    = head_q[EW-1:2];
    assign rx_perr    = head_q[1];
    assign rx_ferr    = head_q[0];
    assign rx_valid   = valid_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboarded bench: u0 is 8N1 with a 4-deep FIFO, u1 is 8E1; both run 16 clk per oversample tick (256 clk/bit).
module tb_uart_rx_fifo;

    localparam int CLK_HZ = 16000000;
    localparam int BAUD   = 62500;
    localparam int BC     = 256;
    localparam int BCF    = 248;

    logic       clk = 1'b0;
    logic       rst0_n, rst1_n, rxd0, rxd1, rdy0, rdy1, clr0, clr1;
    logic [7:0] data0, data1;
    logic       perr0, ferr0, vld0, ovf0, perr1, ferr1, vld1, ovf1;
    logic [2:0] cnt0;
    logic [4:0] cnt1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int chg0 = 0;
    logic [2:0] prev0 = 3'd0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] e0, e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset(rst0_n), .rxd(rxd0), .rx_data(data0), .rx_perr(perr0), .rx_ferr(ferr0),
        .rx_valid(vld0), .rx_ready(rdy0), .overflow(ovf0), .clr_ovf(clr0), .fifo_count(cnt0));

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(16)) u1 (
        .clk(clk), .reset(rst1_n), .rxd(rxd1), .rx_data(data1), .rx_perr(perr1), .rx_ferr(ferr1),
        .rx_valid(vld1), .rx_ready(rdy1), .overflow(ovf1), .clr_ovf(clr1), .fifo_count(cnt1));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst0_n && vld0 && rdy0) begin
            if (q0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop0_unexpected: got 0x%0h, expected no entry", {data0, perr0, ferr0});
            end else begin
                e0 = q0.pop_front();
                chk("pop0 {data,perr,ferr}", {22'd0, data0, perr0, ferr0}, {22'd0, e0});
            end
        end
    end

    always @(negedge clk) begin
        if (rst1_n && vld1 && rdy1) begin
            if (q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop1_unexpected: got 0x%0h, expected no entry", {data1, perr1, ferr1});
            end else begin
                e1 = q1.pop_front();
                chk("pop1 {data,perr,ferr}", {22'd0, data1, perr1, ferr1}, {22'd0, e1});
            end
        end
    end

    always @(negedge clk) begin
        if (cnt0 != prev0) chg0 = cyc;
        prev0 = cnt0;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align16();
        do step(1); while (cyc % 16 != 0);
    endtask

    task automatic send(input int line, input logic [7:0] d, input bit par, input logic pbit,
                        input logic stopb, input int bc);
        logic [10:0] fr;
        int nb;
        fr      = '1;
        fr[0]   = 1'b0;
        fr[8:1] = d;
        if (par) begin
            fr[9]  = pbit;
            fr[10] = stopb;
            nb     = 11;
        end else begin
            fr[9]  = stopb;
            nb     = 10;
        end
        for (int i = 0; i < nb; i++) begin
            if (line == 0) rxd0 = fr[i];
            else           rxd1 = fr[i];
            step(bc);
        end
        if (line == 0) rxd0 = 1'b1;
        else           rxd1 = 1'b1;
    endtask

    task automatic drain0(input string name, input int lim);
        int n = 0;
        rdy0 = 1'b1;
        while ((q0.size() != 0 || vld0) && n < lim) begin
            step(1);
            n++;
        end
        chk(name, q0.size(), 0);
    endtask

    task automatic drain1(input string name, input int lim);
        int n = 0;
        rdy1 = 1'b1;
        while ((q1.size() != 0 || vld1) && n < lim) begin
            step(1);
            n++;
        end
        chk(name, q1.size(), 0);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation did not complete within cycle budget");
        $fatal(1);
    end

    initial begin
        int t0, t1, lat, n;
        rst0_n = 1'b0; rst1_n = 1'b0;
        rxd0 = 1'b1; rxd1 = 1'b1;
        rdy0 = 1'b0; rdy1 = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0;
        step(5);
        chk("reset rx_data", data0, 0);
        chk("reset rx_valid", vld0, 0);
        chk("reset rx_perr/ferr", {perr0, ferr0}, 0);
        chk("reset overflow", ovf0, 0);
        chk("reset fifo_count", cnt0, 0);
        rst0_n = 1'b1; rst1_n = 1'b1;
        step(20);

        // 8N1 single character, then a one-cycle pop
        q0.push_back({8'h01, 2'b00});
        send(0, 8'h01, 0, 1'b0, 1'b1, BC);
        chk("8n1 rx_valid", vld0, 1);
        chk("8n1 rx_data", data0, 8'h01);
        chk("8n1 perr/ferr", {perr0, ferr0}, 0);
        rdy0 = 1'b1;
        step(1);
        rdy0 = 1'b0;
        chk("8n1 valid after pop", vld0, 0);
        chk("8n1 count after pop", cnt0, 0);

        // stop bit low: framing error, and the trailing low must not push a second entry
        q0.push_back({8'h3C, 2'b01});
        send(0, 8'h3C, 0, 1'b0, 1'b0, BC);
        step(3 * BC);
        chk("ferr count", cnt0, 1);
        chk("ferr flag", ferr0, 1);
        drain0("ferr drain", 100);
        rdy0 = 1'b0;

        // short low glitch on idle line
        rxd0 = 1'b0;
        step(8);
        rxd0 = 1'b1;
        step(3 * BC);
        chk("glitch count", cnt0, 0);
        chk("glitch valid", vld0, 0);

        // overflow with consumer stalled
        align16();
        t0 = cyc;
        q0.push_back({8'h11, 2'b00});
        send(0, 8'h11, 0, 1'b0, 1'b1, BC);
        lat = chg0 - t0;
        q0.push_back({8'h22, 2'b00});
        send(0, 8'h22, 0, 1'b0, 1'b1, BC);
        q0.push_back({8'h33, 2'b00});
        send(0, 8'h33, 0, 1'b0, 1'b1, BC);
        q0.push_back({8'h44, 2'b00});
        send(0, 8'h44, 0, 1'b0, 1'b1, BC);
        chk("ovf not yet", ovf0, 0);
        send(0, 8'h55, 0, 1'b0, 1'b1, BC);
        chk("ovf count", cnt0, 4);
        chk("ovf flag", ovf0, 1);
        clr0 = 1'b1;
        step(1);
        clr0 = 1'b0;
        chk("ovf cleared", ovf0, 0);

        // full FIFO, pop exactly in the push cycle; same tick phase as the 0x11 frame
        align16();
        t1 = cyc;
        q0.push_back({8'h66, 2'b00});
        fork
            send(0, 8'h66, 0, 1'b0, 1'b1, BC);
            begin
                n = 0;
                while (cyc != t1 + lat - 1 && n < 12 * BC) begin
                    step(1);
                    n++;
                end
                rdy0 = 1'b1;
                step(1);
                rdy0 = 1'b0;
            end
        join
        chk("full+pop count", cnt0, 4);
        chk("full+pop overflow", ovf0, 0);
        drain0("full+pop drain", 100);
        rdy0 = 1'b0;

        // reset during data bit 4 with a stale entry buffered
        send(0, 8'h77, 0, 1'b0, 1'b1, BC);
        chk("pre-reset count", cnt0, 1);
        rxd0 = 1'b0;
        step(5 * BC + BC / 2);
        rst0_n = 1'b0;
        step(2);
        chk("mid-frame reset count", cnt0, 0);
        chk("mid-frame reset valid", vld0, 0);
        chk("mid-frame reset data", data0, 0);
        rxd0 = 1'b1;
        step(2);
        rst0_n = 1'b1;
        step(2 * BC);
        q0.push_back({8'h5A, 2'b00});
        send(0, 8'h5A, 0, 1'b0, 1'b1, BC);
        step(BC);
        chk("post-reset count", cnt0, 1);
        chk("post-reset data", data0, 8'h5A);
        drain0("post-reset drain", 100);

        // back-to-back at +3% baud
        q0.push_back({8'h00, 2'b00});
        q0.push_back({8'hFF, 2'b00});
        send(0, 8'h00, 0, 1'b0, 1'b1, BCF);
        send(0, 8'hFF, 0, 1'b0, 1'b1, BCF);
        step(BC);
        drain0("b2b drain", 100);
        chk("b2b overflow", ovf0, 0);

        // even parity on u1
        rdy1 = 1'b1;
        q1.push_back({8'hA5, 2'b00});
        send(1, 8'hA5, 1, 1'b0, 1'b1, BC);
        q1.push_back({8'hA5, 2'b10});
        send(1, 8'hA5, 1, 1'b1, 1'b1, BC);
        step(BC);
        drain1("parity drain", 100);
        chk("parity count", cnt1, 0);
        chk("parity overflow", ovf1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
